// File: rtl/io_pkg.sv
// Shared definitions for the board-level I/O conditioning blocks.
package io_pkg;

  localparam int unsigned DEFAULT_STABLE_CYCLES = 65536;
  localparam int unsigned DEFAULT_LONG_CYCLES   = 12000000;

  typedef enum logic [1:0] {
    StIdle,
    StPress,
    StHeld
  } press_state_e;

  function automatic bit params_ok(input int unsigned n_btn,
                                   input int unsigned stable_cycles,
                                   input int unsigned long_cycles);
    return (n_btn >= 1) && (stable_cycles >= 2) && (long_cycles > stable_cycles);
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button: two-flop synchroniser, stability-counter debouncer and press/hold FSM.
module button_channel
  import io_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int unsigned LONG_CYCLES   = DEFAULT_LONG_CYCLES,
  parameter bit          ACTIVE_LOW    = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_raw_i,
  output logic state_o,
  output logic pressed_o,
  output logic released_o,
  output logic long_press_o,
  output logic held_o
);

  localparam int unsigned StableW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam int unsigned LongW   = (LONG_CYCLES > 2) ? $clog2(LONG_CYCLES) : 1;
  localparam logic        RelLvl  = ACTIVE_LOW;

  logic               sync1_q, sync2_q;
  logic               level;
  logic [StableW-1:0] deb_cnt_q, deb_cnt_d;
  logic               state_q, state_d;
  logic               rise, fall;

  press_state_e       fsm_q, fsm_d;
  logic [LongW-1:0]   hold_cnt_q, hold_cnt_d;
  logic               pressed_q, pressed_d;
  logic               released_q, released_d;
  logic               long_q, long_d;
  logic               held_q, held_d;

  // Normalise polarity so that 1 always means pressed.
  assign level = sync2_q ^ ACTIVE_LOW;

  always_comb begin
    deb_cnt_d = '0;
    state_d   = state_q;
    rise      = 1'b0;
    fall      = 1'b0;
    if (level != state_q) begin
      if (deb_cnt_q == StableW'(STABLE_CYCLES - 1)) begin
        state_d = ~state_q;
        rise    = ~state_q;
        fall    = state_q;
      end else begin
        deb_cnt_d = deb_cnt_q + StableW'(1);
      end
    end
  end

  always_comb begin
    fsm_d      = fsm_q;
    hold_cnt_d = hold_cnt_q;
    pressed_d  = 1'b0;
    released_d = 1'b0;
    long_d     = 1'b0;
    unique case (fsm_q)
      StIdle: begin
        if (rise) begin
          fsm_d      = StPress;
          pressed_d  = 1'b1;
          hold_cnt_d = '0;
        end
      end
      StPress: begin
        // A release in the same cycle as the long threshold wins.
        if (fall) begin
          fsm_d      = StIdle;
          released_d = 1'b1;
        end else if (hold_cnt_q == LongW'(LONG_CYCLES - 1)) begin
          fsm_d  = StHeld;
          long_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + LongW'(1);
        end
      end
      StHeld: begin
        if (fall) begin
          fsm_d      = StIdle;
          released_d = 1'b1;
        end
      end
      default: fsm_d = StIdle;
    endcase
    held_d = (fsm_d == StHeld);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q    <= RelLvl;
      sync2_q    <= RelLvl;
      deb_cnt_q  <= '0;
      state_q    <= 1'b0;
      fsm_q      <= StIdle;
      hold_cnt_q <= '0;
      pressed_q  <= 1'b0;
      released_q <= 1'b0;
      long_q     <= 1'b0;
      held_q     <= 1'b0;
    end else begin
      sync1_q    <= btn_raw_i;
      sync2_q    <= sync1_q;
      deb_cnt_q  <= deb_cnt_d;
      state_q    <= state_d;
      fsm_q      <= fsm_d;
      hold_cnt_q <= hold_cnt_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
      long_q     <= long_d;
      held_q     <= held_d;
    end
  end

  assign state_o      = state_q;
  assign pressed_o    = pressed_q;
  assign released_o   = released_q;
  assign long_press_o = long_q;
  assign held_o       = held_q;

endmodule

// File: rtl/button_debouncer.sv
// Multi-channel push-button conditioner: N_BTN independent button_channel instances.
module button_debouncer
  import io_pkg::*;
#(
  parameter int unsigned N_BTN         = 4,
  parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int unsigned LONG_CYCLES   = DEFAULT_LONG_CYCLES,
  parameter bit          ACTIVE_LOW    = 1'b1
) (
  input  logic             hwclk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_state,
  output logic [N_BTN-1:0] pressed,
  output logic [N_BTN-1:0] released,
  output logic [N_BTN-1:0] long_press,
  output logic [N_BTN-1:0] held
);

  if (!params_ok(N_BTN, STABLE_CYCLES, LONG_CYCLES)) begin : gen_param_check
    $error("button_debouncer: illegal N_BTN/STABLE_CYCLES/LONG_CYCLES");
  end

  for (genvar i = 0; i < N_BTN; i++) begin : gen_chan
    button_channel #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .LONG_CYCLES  (LONG_CYCLES),
      .ACTIVE_LOW   (ACTIVE_LOW)
    ) u_chan (
      .clk_i       (hwclk),
      .rst_i       (rst),
      .btn_raw_i   (btn_raw[i]),
      .state_o     (btn_state[i]),
      .pressed_o   (pressed[i]),
      .released_o  (released[i]),
      .long_press_o(long_press[i]),
      .held_o      (held[i])
    );
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Randomised and directed bench for button_debouncer against an event-timestamp model.
module tb_button_debouncer;

  localparam int unsigned NB     = 2;
  localparam int unsigned STABLE = 4;
  localparam int unsigned LONG   = 16;

  logic          hwclk = 1'b0;
  logic          rst   = 1'b1;
  logic [NB-1:0] btn_raw = '1;
  logic [NB-1:0] btn_state, pressed, released, long_press, held;

  int errors = 0;
  int checks = 0;

  button_debouncer #(
    .N_BTN        (NB),
    .STABLE_CYCLES(STABLE),
    .LONG_CYCLES  (LONG),
    .ACTIVE_LOW   (1'b1)
  ) dut (
    .hwclk     (hwclk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .btn_state (btn_state),
    .pressed   (pressed),
    .released  (released),
    .long_press(long_press),
    .held      (held)
  );

  always #5 hwclk = ~hwclk;

  // Model: raw pins pass a 2-deep delay, a press/release is accepted after STABLE consecutive
  // disagreeing samples, and long-press fires LONG edges after the press timestamp.
  int            cyc = 0;
  logic [NB-1:0] m_s1 = '1, m_s2 = '1;
  logic [NB-1:0] m_state = '0, m_held = '0;
  logic [NB-1:0] e_pr = '0, e_rl = '0, e_lp = '0;
  int            m_run   [NB];
  int            m_pedge [NB];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_step(input logic [NB-1:0] raw, input logic r);
    cyc++;
    e_pr = '0;
    e_rl = '0;
    e_lp = '0;
    if (r) begin
      m_s1    = '1;
      m_s2    = '1;
      m_state = '0;
      m_held  = '0;
      for (int c = 0; c < NB; c++) m_run[c] = 0;
    end else begin
      for (int c = 0; c < NB; c++) begin
        logic lvl;
        lvl = ~m_s2[c];
        if (lvl != m_state[c]) m_run[c]++;
        else m_run[c] = 0;
        if (m_run[c] == STABLE) begin
          m_run[c]   = 0;
          m_state[c] = lvl;
          if (lvl) begin
            e_pr[c]    = 1'b1;
            m_pedge[c] = cyc;
          end else begin
            e_rl[c]   = 1'b1;
            m_held[c] = 1'b0;
          end
        end else if (m_state[c] && !m_held[c] && (cyc - m_pedge[c] == LONG)) begin
          e_lp[c]   = 1'b1;
          m_held[c] = 1'b1;
        end
        m_s2[c] = m_s1[c];
        m_s1[c] = raw[c];
      end
    end
  endtask

  task automatic tick(input logic [NB-1:0] raw, input logic r);
    @(negedge hwclk);
    btn_raw = raw;
    rst     = r;
    @(posedge hwclk);
    #1;
    model_step(raw, r);
    check_eq("btn_state", 32'(btn_state), 32'(m_state));
    check_eq("pressed", 32'(pressed), 32'(e_pr));
    check_eq("released", 32'(released), 32'(e_rl));
    check_eq("long_press", 32'(long_press), 32'(e_lp));
    check_eq("held", 32'(held), 32'(m_held));
    check_eq("one_pulse", 32'((pressed & released) | (pressed & long_press)
                              | (released & long_press)), 32'(0));
  endtask

  initial begin
    for (int c = 0; c < NB; c++) begin
      m_run[c]   = 0;
      m_pedge[c] = 0;
    end

    // Reset then idle: every output must stay 0.
    tick(2'b11, 1'b1);
    tick(2'b11, 1'b1);
    for (int k = 0; k < 30; k++) begin
      tick(2'b11, 1'b0);
      check_eq("idle_outputs", 32'({btn_state, pressed, released, long_press, held}), 32'(0));
    end

    // Clean press on ch0 held 40 cycles: press on edge 6, long-press 16 edges later.
    for (int k = 1; k <= 40; k++) begin
      tick(2'b10, 1'b0);
      check_eq("clean_press_edge6", 32'(pressed[0]), 32'(k == 6));
      check_eq("long_press_edge22", 32'(long_press[0]), 32'(k == 22));
      check_eq("held_from_22", 32'(held[0]), 32'(k >= 22));
      check_eq("ch1_untouched", 32'(btn_state[1] | pressed[1]), 32'(0));
    end
    // Release: released, held drop and btn_state drop all on edge 6.
    for (int k = 1; k <= 10; k++) begin
      tick(2'b11, 1'b0);
      check_eq("release_edge6", 32'(released[0]), 32'(k == 6));
      check_eq("held_drop", 32'(held[0]), 32'(k < 6));
      check_eq("state_drop", 32'(btn_state[0]), 32'(k < 6));
    end

    // Bounce shorter than the stability window is never accepted.
    for (int k = 0; k < 24; k++) begin
      tick(((k / 2) % 2 == 0) ? 2'b10 : 2'b11, 1'b0);
      check_eq("bounce_state", 32'(btn_state[0] | pressed[0] | released[0]), 32'(0));
    end
    for (int k = 0; k < 10; k++) begin
      tick(2'b11, 1'b0);
      check_eq("bounce_settle", 32'(btn_state[0] | pressed[0] | released[0]), 32'(0));
    end

    // Simultaneous press on both channels.
    for (int k = 1; k <= 8; k++) begin
      tick(2'b00, 1'b0);
      check_eq("simul_press", 32'(pressed), (k == 6) ? 32'h3 : 32'h0);
    end
    for (int k = 0; k < 20; k++) tick(2'b10, 1'b0);
    // Short press of ch1 while ch0 is held.
    for (int k = 0; k < 8; k++) tick(2'b00, 1'b0);
    for (int k = 0; k < 8; k++) begin
      tick(2'b10, 1'b0);
      check_eq("ch0_held_kept", 32'(held[0]), 32'(1));
    end

    // Reset mid-hold: outputs clear, no release pulse, press re-debounced afterwards.
    tick(2'b10, 1'b1);
    check_eq("rst_clears", 32'({btn_state, pressed, released, long_press, held}), 32'(0));
    for (int k = 1; k <= 8; k++) begin
      tick(2'b10, 1'b0);
      check_eq("post_rst_press", 32'(pressed[0]), 32'(k == 6));
      check_eq("post_rst_norel", 32'(released[0]), 32'(0));
    end

    // Random segments of constant pin levels with occasional resets.
    for (int s = 0; s < 400; s++) begin
      logic [NB-1:0] raw;
      int            len;
      raw = NB'($urandom_range(0, 3));
      len = $urandom_range(1, 30);
      for (int k = 0; k < len; k++) tick(raw, ($urandom_range(0, 199) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
